// File: rtl/inference_sequencer.sv
// Top-level digit-inference controller: clears and enables the two dense layers in turn,
// waits on each with a timeout, then runs a serial signed argmax over the layer-2 scores.
module inference_sequencer #(
    parameter int unsigned N_CLASSES  = 10,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 4095,
    localparam int unsigned IdxW      = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [IdxW-1:0]           digit_o,
    output logic                      layer_reset_o,
    output logic                      l1_enable_o,
    input  logic                      l1_done_i,
    output logic                      l2_enable_o,
    input  logic                      l2_done_i,
    output logic [IdxW-1:0]           score_idx_o,
    input  logic signed [SCORE_W-1:0] score_data_i
);

    localparam int unsigned CntMax = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] ClrLast     = CntW'(CLR_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(N_CLASSES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StL1,
        StL2,
        StArgmax,
        StFin,
        StErr
    } state_e;

    state_e                    state_q;
    logic [CntW-1:0]           cnt_q;
    logic [IdxW-1:0]           score_idx_q;
    logic signed [SCORE_W-1:0] best_q;
    logic [IdxW-1:0]           best_idx_q;
    logic [IdxW-1:0]           digit_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      error_q;
    logic                      layer_reset_q;
    logic                      l1_enable_q;
    logic                      l2_enable_q;

    logic                      take;
    logic [IdxW-1:0]           cand_idx;
    logic                      layer_done;

    // Index 0 always loads; later indices win only on strictly greater, so ties keep the lowest.
    assign take       = (score_idx_q == '0) || (score_data_i > best_q);
    assign cand_idx   = take ? score_idx_q : best_idx_q;
    assign layer_done = (state_q == StL1) ? l1_done_i : l2_done_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            score_idx_q   <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            digit_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            layer_reset_q <= 1'b0;
            l1_enable_q   <= 1'b0;
            l2_enable_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q       <= StClear;
                        busy_q        <= 1'b1;
                        error_q       <= 1'b0;
                        layer_reset_q <= 1'b1;
                        cnt_q         <= '0;
                    end
                end
                StClear: begin
                    if (cnt_q == ClrLast) begin
                        state_q       <= StL1;
                        layer_reset_q <= 1'b0;
                        l1_enable_q   <= 1'b1;
                        cnt_q         <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StL1, StL2: begin
                    if (layer_done) begin
                        cnt_q <= '0;
                        if (state_q == StL1) begin
                            state_q     <= StL2;
                            l2_enable_q <= 1'b1;
                        end else begin
                            state_q     <= StArgmax;
                            score_idx_q <= '0;
                        end
                    end else if (cnt_q == TimeoutLast) begin
                        state_q     <= StErr;
                        cnt_q       <= '0;
                        l1_enable_q <= 1'b0;
                        l2_enable_q <= 1'b0;
                        done_q      <= 1'b1;
                        error_q     <= 1'b1;
                        digit_q     <= '1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StArgmax: begin
                    if (take) begin
                        best_q     <= score_data_i;
                        best_idx_q <= score_idx_q;
                    end
                    if (score_idx_q == LastIdx) begin
                        // Last score is folded in here so the result is ready with done.
                        state_q     <= StFin;
                        score_idx_q <= '0;
                        digit_q     <= cand_idx;
                        done_q      <= 1'b1;
                        l1_enable_q <= 1'b0;
                        l2_enable_q <= 1'b0;
                    end else begin
                        score_idx_q <= score_idx_q + IdxW'(1);
                    end
                end
                StFin, StErr: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign digit_o       = digit_q;
    assign layer_reset_o = layer_reset_q;
    assign l1_enable_o   = l1_enable_q;
    assign l2_enable_o   = l2_enable_q;
    assign score_idx_o   = score_idx_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: table of score sets with expected digits, plus
// hand-written timeout, busy-start, mid-run reset and back-to-back sequences.
module tb_inference_sequencer;

    localparam int NC  = 10;
    localparam int CLR = 2;
    localparam int TO  = 4095;
    // Sampling edge k, then CLEAR x2, L1, L2, ARGMAX x10: done is seen after edge k+14.
    localparam int LAT = CLR + NC + 2;
    // CLEAR x2, L1, then TO cycles in L2 before ERR.
    localparam int TO_LAT = CLR + 1 + TO;
    localparam int NV = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, error, layer_reset, l1_en, l2_en;
    logic              l1_done, l2_done;
    logic [3:0]        digit, score_idx;
    logic signed [7:0] score_data;
    logic signed [7:0] scores [16];
    logic              l2_ack = 1'b1;

    int checks = 0;
    int failures = 0;
    int exp_prev_digit = 0;

    typedef struct packed {
        logic [79:0] sc;   // score 0 in the top byte
        logic [3:0]  dg;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    assign l1_done    = l1_en;
    assign l2_done    = l2_en & l2_ack;
    assign score_data = scores[score_idx];

    inference_sequencer #(
        .N_CLASSES (NC),
        .SCORE_W   (8),
        .CLR_CYCLES(CLR),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .digit_o      (digit),
        .layer_reset_o(layer_reset),
        .l1_enable_o  (l1_en),
        .l1_done_i    (l1_done),
        .l2_enable_o  (l2_en),
        .l2_done_i    (l2_done),
        .score_idx_o  (score_idx),
        .score_data_i (score_data)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic load(input int v);
        for (int i = 0; i < 16; i++) scores[i] = '0;
        for (int i = 0; i < NC; i++) scores[i] = vecs[v].sc[79-8*i -: 8];
    endtask

    task automatic run(input string nm, input int exp_dg, input int exp_err, input int exp_lat,
                       input bit pulse);
        int n;
        int lr;
        int extra;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, " busy_after_start"}, int'(busy), 1);
        chk({nm, " error_cleared"}, int'(error), 0);
        chk({nm, " digit_kept"}, int'(digit), exp_prev_digit);
        lr = int'(layer_reset);
        n = 0;
        while (!done && n < exp_lat + 40) begin
            @(posedge clk);
            #1;
            n++;
            if (layer_reset) lr++;
            start = pulse && (n == 2 || n == 8);
        end
        start = 1'b0;
        chk({nm, " latency"}, n, exp_lat);
        chk({nm, " digit"}, int'(digit), exp_dg);
        chk({nm, " error"}, int'(error), exp_err);
        chk({nm, " busy_with_done"}, int'(busy), 1);
        chk({nm, " layer_reset_cycles"}, lr, CLR);
        @(posedge clk);
        #1;
        chk({nm, " done_one_cycle"}, int'(done), 0);
        chk({nm, " busy_falls_with_done"}, int'(busy), 0);
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        chk({nm, " stays_idle"}, extra, 0);
        exp_prev_digit = exp_dg;
    endtask

    initial begin
        int d1;
        int d2;
        int idle_gap;
        int n;
        int cnt;

        vecs[0] = '{sc: {8'(-5), 8'(3), 8'(7), 8'(7), 8'(-128), 8'(0), 8'(1), 8'(2), 8'(6),
                         8'(-1)}, dg: 4'd2};
        vecs[1] = '{sc: {10{8'h80}}, dg: 4'd0};
        vecs[2] = '{sc: {{9{8'(0)}}, 8'(127)}, dg: 4'd9};
        vecs[3] = '{sc: {10{8'(5)}}, dg: 4'd0};
        vecs[4] = '{sc: {8'(-1), 8'(-2), 8'(-3), 8'(-4), 8'(-5), 8'(-6), 8'(-7), 8'(-8),
                         8'(-9), 8'(-10)}, dg: 4'd0};
        vecs[5] = '{sc: {8'(0), 8'(1), 8'(2), 8'(3), 8'(4), 8'(5), 8'(6), 8'(7), 8'(8),
                         8'(9)}, dg: 4'd9};
        vecs[6] = '{sc: {8'(127), {8{8'(0)}}, 8'(127)}, dg: 4'd0};
        vecs[7] = '{sc: {{4{8'h80}}, 8'(-127), {5{8'h80}}}, dg: 4'd4};
        vecs[8] = '{sc: {8'(10), 8'(-20), 8'(50), 8'(-128), 8'(49), 8'(51), 8'(-1), 8'(51),
                         8'(0), 8'(-2)}, dg: 4'd5};

        for (int i = 0; i < 16; i++) scores[i] = '0;

        // Reset state
        #12;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst error", int'(error), 0);
        chk("rst digit", int'(digit), 0);
        chk("rst layer_reset", int'(layer_reset), 0);
        chk("rst enables", int'({l1_en, l2_en}), 0);
        chk("rst score_idx", int'(score_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            load(v);
            run($sformatf("vec%0d", v), int'(vecs[v].dg), 0, LAT, 1'b0);
        end

        // l2_done never arrives: timeout in L2
        load(0);
        l2_ack = 1'b0;
        run("timeout", 15, 1, TO_LAT, 1'b0);
        l2_ack = 1'b1;
        run("after_err", 2, 0, LAT, 1'b0);

        // start pulses during L1 and ARGMAX are ignored
        load(8);
        run("busy_start", 5, 0, LAT, 1'b1);

        // Asynchronous reset mid-ARGMAX
        load(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("midrst in_argmax", int'(l1_en & l2_en), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst enables", int'({l1_en, l2_en}), 0);
        chk("midrst layer_reset", int'(layer_reset), 0);
        chk("midrst digit", int'(digit), 0);
        chk("midrst score_idx", int'(score_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) cnt++;
        end
        chk("midrst no_done", cnt, 0);
        exp_prev_digit = 0;
        load(3);
        run("post_rst", 0, 0, LAT, 1'b0);

        // start held high: back-to-back runs with one IDLE cycle in between
        load(5);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        d1 = -1;
        d2 = -1;
        idle_gap = -1;
        n = 0;
        while (d2 < 0 && n < 3 * LAT + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done && d1 < 0) d1 = n;
            else if (done) d2 = n;
            if (d1 >= 0 && n == d1 + 1) idle_gap = int'(busy);
        end
        start = 1'b0;
        chk("b2b first_done", d1, LAT);
        chk("b2b second_done", d2, 2 * LAT + 2);
        chk("b2b idle_between", idle_gap, 0);
        chk("b2b digit", int'(digit), 9);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b stops", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
